turing_engine: RTL

//  Parametrised single-tape binary Turing machine engine. Executes a
//  run-time loadable transition table over a TAPE_LEN-bit tape, one step
//  per clock. Reports halt, tape-boundary and step-timeout outcomes.

---
 rtl/turing_engine_if.sv | 31 +++
 rtl/turing_engine.sv | 129 ++++++++++++
 2 files changed

// File: rtl/turing_engine_if.sv
// rtl/turing_engine_if.sv - host-side port bundle for turing_engine
interface turing_engine_if #(
   parameter int TAPE_LEN = 10,
   parameter int STATE_W  = 2,
   parameter int HEAD_W   = 4,
   parameter int STEP_W   = 8
);
   logic                tbl_we;
   logic [STATE_W:0]    tbl_addr;
   logic [STATE_W+2:0]  tbl_data;
   logic                start;
   logic [TAPE_LEN-1:0] tape_in;
   logic [HEAD_W-1:0]   head_init;
   logic                busy;
   logic                done;
   logic [1:0]          status;
   logic [TAPE_LEN-1:0] tape_out;
   logic [HEAD_W-1:0]   head_pos;
   logic [STATE_W-1:0]  cur_state;
   logic [STEP_W-1:0]   steps;

   modport master (
      output tbl_we, tbl_addr, tbl_data, start, tape_in, head_init,
      input  busy, done, status, tape_out, head_pos, cur_state, steps
   );

   modport slave (
      input  tbl_we, tbl_addr, tbl_data, start, tape_in, head_init,
      output busy, done, status, tape_out, head_pos, cur_state, steps
   );
endinterface

// File: rtl/turing_engine.sv
// rtl/turing_engine.sv - single-tape binary Turing machine, one step per clock
module turing_engine #(
   parameter int TAPE_LEN   = 10,
   parameter int NUM_STATES = 4,
   parameter int STATE_W    = 2,
   parameter int HEAD_W     = 4,
   parameter int MAX_STEPS  = 255,
   parameter int STEP_W     = 8
) (
   input logic             clk,
   input logic             rst_n,
   turing_engine_if.slave  bus
);
   localparam int ENTRIES = 2 * NUM_STATES;
   localparam int E_W     = STATE_W + 3;

   localparam logic [1:0] MV_STAY = 2'b00;
   localparam logic [1:0] MV_R    = 2'b01;
   localparam logic [1:0] MV_L    = 2'b10;
   localparam logic [1:0] MV_HALT = 2'b11;

   localparam logic [1:0] ST_NONE    = 2'b00;
   localparam logic [1:0] ST_HALT    = 2'b01;
   localparam logic [1:0] ST_BOUND   = 2'b10;
   localparam logic [1:0] ST_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t                fsm;
   logic [E_W-1:0]      tbl [ENTRIES];
   logic [TAPE_LEN-1:0] tape_r;
   logic [HEAD_W-1:0]   head_r;
   logic [STATE_W-1:0]  state_r;
   logic [STEP_W-1:0]   steps_r;
   logic [1:0]          status_r;
   logic                busy_r;
   logic                done_r;

   logic [STATE_W:0]    idx;
   logic [E_W-1:0]      ent;
   logic [STATE_W-1:0]  ent_ns;
   logic                ent_sym;
   logic [1:0]          ent_mv;
   logic [STEP_W-1:0]   steps_inc;
   logic                hit_bound;
   logic [HEAD_W-1:0]   head_next;

   always_comb begin
      idx = {state_r, tape_r[head_r]};
      ent = '0;
      // Wrapped states beyond NUM_STATES read as an all-zero entry.
      if (int'(idx) < ENTRIES)
         ent = tbl[idx];
      ent_ns    = ent[E_W-1:3];
      ent_sym   = ent[2];
      ent_mv    = ent[1:0];
      steps_inc = steps_r + STEP_W'(1);
      hit_bound = (ent_mv == MV_R && head_r == HEAD_W'(TAPE_LEN - 1)) ||
                  (ent_mv == MV_L && head_r == '0);
      case (ent_mv)
         MV_R:    head_next = head_r + HEAD_W'(1);
         MV_L:    head_next = head_r - HEAD_W'(1);
         default: head_next = head_r;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm      <= IDLE;
         tape_r   <= '0;
         head_r   <= '0;
         state_r  <= '0;
         steps_r  <= '0;
         status_r <= ST_NONE;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         for (int i = 0; i < ENTRIES; i++)
            tbl[i] <= '0;
      end else begin
         done_r <= 1'b0;
         if (fsm != RUN && bus.tbl_we && int'(bus.tbl_addr) < ENTRIES)
            tbl[bus.tbl_addr] <= bus.tbl_data;
         case (fsm)
            IDLE, DONE: begin
               if (bus.start) begin
                  tape_r  <= bus.tape_in;
                  head_r  <= bus.head_init;
                  state_r <= '0;
                  steps_r <= '0;
                  if (int'(bus.head_init) >= TAPE_LEN) begin
                     fsm      <= DONE;
                     status_r <= ST_BOUND;
                     done_r   <= 1'b1;
                  end else begin
                     fsm      <= RUN;
                     status_r <= ST_NONE;
                     busy_r   <= 1'b1;
                  end
               end
            end
            RUN: begin
               tape_r[head_r] <= ent_sym;
               state_r        <= ent_ns;
               steps_r        <= steps_inc;
               // Halt and bound freeze the head; timeout still applies the move.
               if (ent_mv == MV_HALT) begin
                  fsm <= DONE; busy_r <= 1'b0; done_r <= 1'b1; status_r <= ST_HALT;
               end else if (hit_bound) begin
                  fsm <= DONE; busy_r <= 1'b0; done_r <= 1'b1; status_r <= ST_BOUND;
               end else begin
                  head_r <= head_next;
                  if (steps_inc == STEP_W'(MAX_STEPS)) begin
                     fsm <= DONE; busy_r <= 1'b0; done_r <= 1'b1; status_r <= ST_TIMEOUT;
                  end
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.status    = status_r;
   assign bus.tape_out  = tape_r;
   assign bus.head_pos  = head_r;
   assign bus.cur_state = state_r;
   assign bus.steps     = steps_r;
endmodule
